fc_argmax: RTL and testbench

Classifier output stage directly downstream of the final fully-connected layer. It captures the signed 8-bit logits written by the FC output write port into an internal score bank. When the FC layer signals done, it scans the bank sequentially and produces the winning class index, the top score, and the top-minus-second margin. The result is held on a valid/ready handshake toward the PS-side result register interface.

---
 rtl/fc_argmax_if.sv | 29 ++
 rtl/fc_argmax.sv | 125 ++++++++++++
 tb/tb_fc_argmax.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_argmax_if.sv
// FC-layer logit write port plus the result handshake toward the PS-side register block.
// The master modport drives the FC/consumer side; the slave modport is the argmax stage.
interface fc_argmax_if #(
  parameter int ADDR_W = 1,
  parameter int CNT_W  = 16
);
  logic                     fc_output_wren_i;
  logic [ADDR_W-1:0]        fc_output_addr_i;
  logic signed [7:0]        fc_output_data_i;
  logic                     fc_done_i;
  logic                     result_valid_o;
  logic                     result_ready_i;
  logic [ADDR_W-1:0]        class_o;
  logic signed [7:0]        max_score_o;
  logic [8:0]               margin_o;
  logic [CNT_W-1:0]         frame_cnt_o;
  logic                     busy_o;
  logic                     overflow_o;

  modport master (
    output fc_output_wren_i, fc_output_addr_i, fc_output_data_i, fc_done_i, result_ready_i,
    input  result_valid_o, class_o, max_score_o, margin_o, frame_cnt_o, busy_o, overflow_o
  );

  modport slave (
    input  fc_output_wren_i, fc_output_addr_i, fc_output_data_i, fc_done_i, result_ready_i,
    output result_valid_o, class_o, max_score_o, margin_o, frame_cnt_o, busy_o, overflow_o
  );
endinterface

// File: rtl/fc_argmax.sv
// Classifier output stage: collects signed logits, scans them for the argmax, top score
// and top-minus-second margin, and holds the result on a valid/ready handshake.
module fc_argmax #(
  parameter int OUTPUT_DIM = 2,
  parameter int ADDR_W     = 1,
  parameter int CNT_W      = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  fc_argmax_if.slave  bus
);
  localparam int                NSLOT    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(OUTPUT_DIM - 1);

  typedef enum logic [1:0] {COLLECT, SCAN, HOLD} state_t;

  state_t                   r_state, w_state_next;
  logic signed [7:0]        r_score [NSLOT];
  logic [ADDR_W-1:0]        r_idx, r_bidx, w_bidx_n;
  logic signed [7:0]        r_best, r_second, w_best_n, w_second_n, w_cur;
  logic [ADDR_W-1:0]        r_class;
  logic signed [7:0]        r_max;
  logic [8:0]               r_margin;
  logic [CNT_W-1:0]         r_frame_cnt;
  logic                     r_valid, r_busy, r_overflow;
  logic                     w_last, w_accept, w_wr_ok;

  // best >= second always holds, so the 9-bit difference lands in 0..255
  function automatic logic [8:0] margin_sub(input logic signed [7:0] best,
                                            input logic signed [7:0] second);
    return {best[7], best} - {second[7], second};
  endfunction

  assign w_last   = (r_state == SCAN) && (r_idx == LAST_IDX);
  assign w_accept = (r_state == HOLD) && r_valid && bus.result_ready_i;
  assign w_wr_ok  = bus.fc_output_wren_i && (32'(bus.fc_output_addr_i) < OUTPUT_DIM);

  always_comb begin
    w_cur      = r_score[r_idx];
    w_best_n   = r_best;
    w_second_n = r_second;
    w_bidx_n   = r_bidx;
    if (w_cur > r_best) begin
      w_second_n = r_best;
      w_best_n   = w_cur;
      w_bidx_n   = r_idx;
    end else if (w_cur > r_second) begin
      w_second_n = w_cur;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      COLLECT: if (bus.fc_done_i) w_state_next = SCAN;
      SCAN:    if (w_last)        w_state_next = HOLD;
      HOLD:    if (w_accept)      w_state_next = COLLECT;
      default:                    w_state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= COLLECT;
      r_busy      <= 1'b0;
      r_overflow  <= 1'b0;
      r_valid     <= 1'b0;
      r_frame_cnt <= '0;
      r_idx       <= '0;
      r_bidx      <= '0;
      r_best      <= 8'sh80;
      r_second    <= 8'sh80;
      r_class     <= '0;
      r_max       <= '0;
      r_margin    <= '0;
      for (int i = 0; i < NSLOT; i++) r_score[i] <= 8'sh80;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != COLLECT);
      if (r_busy && (bus.fc_output_wren_i || bus.fc_done_i)) r_overflow <= 1'b1;
      case (r_state)
        COLLECT: begin
          if (w_wr_ok) r_score[bus.fc_output_addr_i] <= bus.fc_output_data_i;
          if (bus.fc_done_i) begin
            r_idx    <= '0;
            r_bidx   <= '0;
            r_best   <= 8'sh80;
            r_second <= 8'sh80;
          end
        end
        // ---- scan stage: one score per cycle, result latched on the last index
        SCAN: begin
          r_idx    <= r_idx + 1'b1;
          r_best   <= w_best_n;
          r_second <= w_second_n;
          r_bidx   <= w_bidx_n;
          if (w_last) begin
            r_class  <= w_bidx_n;
            r_max    <= w_best_n;
            r_margin <= margin_sub(w_best_n, w_second_n);
          end
        end
        // ---- hold stage: valid rises one cycle after entry, falls after the handshake
        HOLD: begin
          if (!r_valid) begin
            r_valid <= 1'b1;
          end else if (bus.result_ready_i) begin
            r_valid     <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 1'b1;
            for (int i = 0; i < NSLOT; i++) r_score[i] <= 8'sh80;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result_valid_o = r_valid;
  assign bus.class_o        = r_class;
  assign bus.max_score_o    = r_max;
  assign bus.margin_o       = r_margin;
  assign bus.frame_cnt_o    = r_frame_cnt;
  assign bus.busy_o         = r_busy;
  assign bus.overflow_o     = r_overflow;
endmodule

// File: tb/tb_fc_argmax.sv
// Directed bench for fc_argmax: table of two-logit frames plus hand-written corner sequences
// (same-cycle write/done, unwritten index, backpressure/overflow, OUTPUT_DIM=1, reset in scan).
module tb_fc_argmax;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fc_argmax_if #(.ADDR_W(1), .CNT_W(16)) bus0();
  fc_argmax_if #(.ADDR_W(1), .CNT_W(16)) bus1();

  fc_argmax #(.OUTPUT_DIM(2), .ADDR_W(1), .CNT_W(16)) dut0 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus0));
  fc_argmax #(.OUTPUT_DIM(1), .ADDR_W(1), .CNT_W(16)) dut1 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus1));

  typedef struct {
    logic signed [7:0] s0;
    logic signed [7:0] s1;
    logic [0:0]        cls;
    logic [7:0]        mx;
    logic [8:0]        mg;
  } vec_t;

  vec_t vecs [6];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid0(input int exp_lat, input string tag);
    int n = 0;
    while (!bus0.result_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
  endtask

  task automatic accept0(input string tag);
    bus0.result_ready_i = 1'b1;
    tick();
    bus0.result_ready_i = 1'b0;
    exp_cnt0++;
    chk({tag, "_valid_drop"}, bus0.result_valid_o, 0);
    chk({tag, "_busy_after"}, bus0.busy_o, 0);
    chk({tag, "_frame_cnt"}, bus0.frame_cnt_o, exp_cnt0);
  endtask

  task automatic check_result0(input string tag, input logic [0:0] cls,
                               input logic [7:0] mx, input logic [8:0] mg);
    chk({tag, "_class"}, bus0.class_o, cls);
    chk({tag, "_max"}, $unsigned(bus0.max_score_o), mx);
    chk({tag, "_margin"}, bus0.margin_o, mg);
    chk({tag, "_busy"}, bus0.busy_o, 1);
  endtask

  task automatic run_frame0(input logic signed [7:0] s0, input logic signed [7:0] s1,
                            input logic [0:0] cls, input logic [7:0] mx,
                            input logic [8:0] mg, input string tag);
    bus0.fc_output_wren_i = 1'b1;
    bus0.fc_output_addr_i = 1'b0;
    bus0.fc_output_data_i = s0;
    tick();
    bus0.fc_output_addr_i = 1'b1;
    bus0.fc_output_data_i = s1;
    tick();
    bus0.fc_output_wren_i = 1'b0;
    bus0.fc_done_i        = 1'b1;
    tick();
    bus0.fc_done_i        = 1'b0;
    wait_valid0(3, tag);
    check_result0(tag, cls, mx, mg);
    accept0(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, bus0.result_valid_o, 0);
    chk({tag, "_busy"}, bus0.busy_o, 0);
    chk({tag, "_class"}, bus0.class_o, 0);
    chk({tag, "_max"}, $unsigned(bus0.max_score_o), 0);
    chk({tag, "_margin"}, bus0.margin_o, 0);
    chk({tag, "_frame_cnt"}, bus0.frame_cnt_o, 0);
    chk({tag, "_overflow"}, bus0.overflow_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'sd5,    -8'sd6,   1'b0, 8'h05, 9'd11};
    vecs[1] = '{-8'sd20,  -8'sd3,   1'b1, 8'hFD, 9'd17};
    vecs[2] = '{8'sh40,   8'sh40,   1'b0, 8'h40, 9'd0};
    vecs[3] = '{8'sd127,  8'sh80,   1'b0, 8'h7F, 9'd255};
    vecs[4] = '{8'sh80,   8'sd127,  1'b1, 8'h7F, 9'd255};
    vecs[5] = '{-8'sd1,   8'sd0,    1'b1, 8'h00, 9'd1};

    {bus0.fc_output_wren_i, bus0.fc_done_i, bus0.result_ready_i} = 3'b000;
    bus0.fc_output_addr_i = 1'b0;
    bus0.fc_output_data_i = 8'sd0;
    {bus1.fc_output_wren_i, bus1.fc_done_i, bus1.result_ready_i} = 3'b000;
    bus1.fc_output_addr_i = 1'b0;
    bus1.fc_output_data_i = 8'sd0;

    rst_n = 1'b0;
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 6; i++)
      run_frame0(vecs[i].s0, vecs[i].s1, vecs[i].cls, vecs[i].mx, vecs[i].mg,
                 $sformatf("vec%0d", i));

    // repeated write keeps the last value; a write in the done cycle is captured
    bus0.fc_output_wren_i = 1'b1;
    bus0.fc_output_addr_i = 1'b0;
    bus0.fc_output_data_i = 8'sd1;
    tick();
    bus0.fc_output_data_i = 8'sd90;
    tick();
    bus0.fc_output_addr_i = 1'b1;
    bus0.fc_output_data_i = 8'sd80;
    bus0.fc_done_i        = 1'b1;
    tick();
    bus0.fc_output_wren_i = 1'b0;
    bus0.fc_done_i        = 1'b0;
    wait_valid0(3, "samecyc");
    check_result0("samecyc", 1'b0, 8'h5A, 9'd10);
    accept0("samecyc");

    // ready outside HOLD has no effect
    bus0.result_ready_i = 1'b1;
    tick();
    tick();
    bus0.result_ready_i = 1'b0;
    chk("idle_ready_cnt", bus0.frame_cnt_o, exp_cnt0);
    chk("idle_ready_valid", bus0.result_valid_o, 0);

    // only index 1 written with -128: both slots -128
    bus0.fc_output_wren_i = 1'b1;
    bus0.fc_output_addr_i = 1'b1;
    bus0.fc_output_data_i = 8'sh80;
    tick();
    bus0.fc_output_wren_i = 1'b0;
    bus0.fc_done_i        = 1'b1;
    tick();
    bus0.fc_done_i        = 1'b0;
    wait_valid0(3, "missing");
    check_result0("missing", 1'b0, 8'h80, 9'd0);
    accept0("missing");

    // index 0 left unwritten keeps -128 after the previous handshake
    bus0.fc_output_wren_i = 1'b1;
    bus0.fc_output_addr_i = 1'b1;
    bus0.fc_output_data_i = 8'sd5;
    tick();
    bus0.fc_output_wren_i = 1'b0;
    bus0.fc_done_i        = 1'b1;
    tick();
    bus0.fc_done_i        = 1'b0;
    wait_valid0(3, "unwritten");
    check_result0("unwritten", 1'b1, 8'h05, 9'd133);
    accept0("unwritten");

    // backpressure with writes and done injected during HOLD
    chk("ovf_before", bus0.overflow_o, 0);
    bus0.fc_output_wren_i = 1'b1;
    bus0.fc_output_addr_i = 1'b0;
    bus0.fc_output_data_i = 8'sd8;
    tick();
    bus0.fc_output_addr_i = 1'b1;
    bus0.fc_output_data_i = 8'sd3;
    tick();
    bus0.fc_output_wren_i = 1'b0;
    bus0.fc_done_i        = 1'b1;
    tick();
    bus0.fc_done_i        = 1'b0;
    wait_valid0(3, "bp");
    for (int c = 0; c < 10; c++) begin
      bus0.fc_output_wren_i = (c == 3);
      bus0.fc_output_addr_i = 1'b0;
      bus0.fc_output_data_i = 8'sd100;
      bus0.fc_done_i        = (c == 5);
      tick();
      chk($sformatf("bp_valid_c%0d", c), bus0.result_valid_o, 1);
      chk($sformatf("bp_class_c%0d", c), bus0.class_o, 0);
      chk($sformatf("bp_max_c%0d", c), $unsigned(bus0.max_score_o), 8'h08);
    end
    bus0.fc_output_wren_i = 1'b0;
    bus0.fc_done_i        = 1'b0;
    chk("bp_overflow", bus0.overflow_o, 1);
    check_result0("bp", 1'b0, 8'h08, 9'd5);
    accept0("bp");
    run_frame0(-8'sd5, -8'sd7, 1'b0, 8'hFB, 9'd2, "after_bp");
    chk("ovf_sticky", bus0.overflow_o, 1);

    // OUTPUT_DIM=1: address 1 ignored, margin = best + 128, latency 2
    bus1.fc_output_wren_i = 1'b1;
    bus1.fc_output_addr_i = 1'b0;
    bus1.fc_output_data_i = 8'sd10;
    tick();
    bus1.fc_output_addr_i = 1'b1;
    bus1.fc_output_data_i = 8'sd100;
    tick();
    bus1.fc_output_wren_i = 1'b0;
    bus1.fc_done_i        = 1'b1;
    tick();
    bus1.fc_done_i        = 1'b0;
    begin
      int n = 0;
      while (!bus1.result_valid_o && n < 20) begin
        tick();
        n++;
      end
      chk("dim1_latency", n, 2);
    end
    chk("dim1_class", bus1.class_o, 0);
    chk("dim1_max", $unsigned(bus1.max_score_o), 8'h0A);
    chk("dim1_margin", bus1.margin_o, 9'd138);
    bus1.result_ready_i = 1'b1;
    tick();
    bus1.result_ready_i = 1'b0;
    chk("dim1_valid_drop", bus1.result_valid_o, 0);
    chk("dim1_frame_cnt", bus1.frame_cnt_o, 1);

    // reset asserted mid-scan aborts the frame
    bus0.fc_output_wren_i = 1'b1;
    bus0.fc_output_addr_i = 1'b0;
    bus0.fc_output_data_i = 8'sd1;
    tick();
    bus0.fc_output_addr_i = 1'b1;
    bus0.fc_output_data_i = 8'sd2;
    tick();
    bus0.fc_output_wren_i = 1'b0;
    bus0.fc_done_i        = 1'b1;
    tick();
    bus0.fc_done_i        = 1'b0;
    chk("scan_busy", bus0.busy_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_scan");
    chk("rst_scan_dim1_cnt", bus1.frame_cnt_o, 0);
    #2;
    rst_n = 1'b1;
    exp_cnt0 = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("rst_novalid_c%0d", c), bus0.result_valid_o, 0);
    end
    run_frame0(8'sd7, 8'sd9, 1'b1, 8'h09, 9'd2, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
